// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register: the operation selector and a
// small classification helper used by the arithmetic unit.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int OPC_WIDTH = 3;

  // True for the operations whose divisor may be zero.
  function automatic logic is_div_op(input opcode_t opc);
    return (opc == DIV) || (opc == MOD);
  endfunction

endpackage

// File: rtl/instr_register_param_if.sv
// Bus bundle for the instruction register: write request, read request and
// the registered read-side / occupancy outputs.
interface instr_register_param_if
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int RES_WIDTH  = 2 * OP_WIDTH;

  logic                        load_en;
  logic [ADDR_WIDTH-1:0]       write_pointer;
  opcode_t                     opcode;
  logic signed [OP_WIDTH-1:0]  operand_a;
  logic signed [OP_WIDTH-1:0]  operand_b;
  logic                        clear_all;
  logic                        read_en;
  logic [ADDR_WIDTH-1:0]       read_pointer;

  opcode_t                     rd_opc;
  logic signed [OP_WIDTH-1:0]  rd_op_a;
  logic signed [OP_WIDTH-1:0]  rd_op_b;
  logic signed [RES_WIDTH-1:0] rd_result;
  logic                        rd_valid;
  logic                        rd_written;
  logic                        rd_div0;
  logic [ADDR_WIDTH:0]         wr_count;
  logic                        full;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b,
    output clear_all, read_en, read_pointer,
    input  rd_opc, rd_op_a, rd_op_b, rd_result, rd_valid, rd_written,
    input  rd_div0, wr_count, full
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b,
    input  clear_all, read_en, read_pointer,
    output rd_opc, rd_op_a, rd_op_b, rd_result, rd_valid, rd_written,
    output rd_div0, wr_count, full
  );

endinterface

// File: rtl/instr_alu.sv
// Combinational signed arithmetic. Everything is evaluated at double width so
// the full product and -MIN / -1 are exact; a zero divisor yields 0 and div0.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  opcode_t                       opc_i,
  input  logic signed [OP_WIDTH-1:0]    a_i,
  input  logic signed [OP_WIDTH-1:0]    b_i,
  output logic signed [2*OP_WIDTH-1:0]  result_o,
  output logic                          div0_o
);
  localparam int RES_WIDTH = 2 * OP_WIDTH;

  logic signed [RES_WIDTH-1:0] a_ext;
  logic signed [RES_WIDTH-1:0] b_ext;
  logic signed [RES_WIDTH-1:0] b_safe;
  logic                        b_zero;

  assign a_ext  = {{OP_WIDTH{a_i[OP_WIDTH-1]}}, a_i};
  assign b_ext  = {{OP_WIDTH{b_i[OP_WIDTH-1]}}, b_i};
  assign b_zero = (b_i == '0);
  // Divisor forced to 1 when zero so the divider never sees an X-producing operand.
  assign b_safe = b_zero ? RES_WIDTH'(1) : b_ext;

  // Operation select; divide/modulo by zero report 0 with the div0 flag.
  always_comb begin
    result_o = '0;
    div0_o   = is_div_op(opc_i) && b_zero;
    case (opc_i)
      ZERO:    result_o = '0;
      PASSA:   result_o = a_ext;
      PASSB:   result_o = b_ext;
      ADD:     result_o = a_ext + b_ext;
      SUB:     result_o = a_ext - b_ext;
      MULT:    result_o = a_ext * b_ext;
      DIV:     if (!b_zero) result_o = a_ext / b_safe;
      MOD:     if (!b_zero) result_o = a_ext % b_safe;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_param.sv
// Instruction register file: two-stage write pipeline (capture, then compute
// and commit), single-cycle registered read with write-first bypass, and a
// count of distinct written locations.
module instr_register_param
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32,
  parameter int DEPTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_register_param_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int RES_WIDTH  = 2 * OP_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic                        s1_valid_q;
  logic [ADDR_WIDTH-1:0]       s1_ptr_q;
  opcode_t                     s1_opc_q;
  logic signed [OP_WIDTH-1:0]  s1_a_q;
  logic signed [OP_WIDTH-1:0]  s1_b_q;

  logic signed [RES_WIDTH-1:0] alu_result;
  logic                        alu_div0;
  logic                        commit;
  logic                        bypass;

  opcode_t                     mem_opc_q  [DEPTH];
  logic signed [OP_WIDTH-1:0]  mem_a_q    [DEPTH];
  logic signed [OP_WIDTH-1:0]  mem_b_q    [DEPTH];
  logic signed [RES_WIDTH-1:0] mem_res_q  [DEPTH];
  logic                        mem_div0_q [DEPTH];

  logic [DEPTH-1:0]            written_q, written_d;
  logic [ADDR_WIDTH:0]         wr_count_q, wr_count_d;

  logic                        rd_valid_q;
  opcode_t                     rd_opc_q, rd_opc_d;
  logic signed [OP_WIDTH-1:0]  rd_a_q, rd_a_d;
  logic signed [OP_WIDTH-1:0]  rd_b_q, rd_b_d;
  logic signed [RES_WIDTH-1:0] rd_res_q, rd_res_d;
  logic                        rd_written_q, rd_written_d;
  logic                        rd_div0_q, rd_div0_d;

  instr_alu #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .opc_i    (s1_opc_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (alu_result),
    .div0_o   (alu_div0)
  );

  // A clear on the commit edge wins: the stage-1 entry is dropped.
  assign commit = s1_valid_q && !bus.clear_all;
  assign bypass = commit && (s1_ptr_q == bus.read_pointer);

  // Stage 1: capture the request; a new load is accepted even alongside a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_ptr_q   <= '0;
      s1_opc_q   <= ZERO;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= bus.load_en;
      if (bus.load_en) begin
        s1_ptr_q <= bus.write_pointer;
        s1_opc_q <= bus.opcode;
        s1_a_q   <= bus.operand_a;
        s1_b_q   <= bus.operand_b;
      end
    end
  end

  // Stage 2: commit the computed entry into the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_opc_q[i]  <= ZERO;
        mem_a_q[i]    <= '0;
        mem_b_q[i]    <= '0;
        mem_res_q[i]  <= '0;
        mem_div0_q[i] <= 1'b0;
      end
    end else if (commit) begin
      mem_opc_q[s1_ptr_q]  <= s1_opc_q;
      mem_a_q[s1_ptr_q]    <= s1_a_q;
      mem_b_q[s1_ptr_q]    <= s1_b_q;
      mem_res_q[s1_ptr_q]  <= alu_result;
      mem_div0_q[s1_ptr_q] <= alu_div0;
    end
  end

  // Written flags and occupancy: only first writes to a location count.
  always_comb begin
    written_d  = written_q;
    wr_count_d = wr_count_q;
    if (bus.clear_all) begin
      written_d  = '0;
      wr_count_d = '0;
    end else if (commit) begin
      written_d[s1_ptr_q] = 1'b1;
      if (!written_q[s1_ptr_q]) wr_count_d = wr_count_q + (ADDR_WIDTH+1)'(1);
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written_q  <= '0;
      wr_count_q <= '0;
    end else begin
      written_q  <= written_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read data select: bypass the committing entry, else stored data gated by its flag.
  always_comb begin
    rd_opc_d     = ZERO;
    rd_a_d       = '0;
    rd_b_d       = '0;
    rd_res_d     = '0;
    rd_div0_d    = 1'b0;
    rd_written_d = 1'b0;
    if (bypass) begin
      rd_opc_d     = s1_opc_q;
      rd_a_d       = s1_a_q;
      rd_b_d       = s1_b_q;
      rd_res_d     = alu_result;
      rd_div0_d    = alu_div0;
      rd_written_d = 1'b1;
    end else if (written_q[bus.read_pointer]) begin
      rd_opc_d     = mem_opc_q[bus.read_pointer];
      rd_a_d       = mem_a_q[bus.read_pointer];
      rd_b_d       = mem_b_q[bus.read_pointer];
      rd_res_d     = mem_res_q[bus.read_pointer];
      rd_div0_d    = mem_div0_q[bus.read_pointer];
      rd_written_d = 1'b1;
    end
  end

  // Read register: loads on read_en and holds otherwise; rd_valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q   <= 1'b0;
      rd_opc_q     <= ZERO;
      rd_a_q       <= '0;
      rd_b_q       <= '0;
      rd_res_q     <= '0;
      rd_div0_q    <= 1'b0;
      rd_written_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.read_en;
      if (bus.read_en) begin
        rd_opc_q     <= rd_opc_d;
        rd_a_q       <= rd_a_d;
        rd_b_q       <= rd_b_d;
        rd_res_q     <= rd_res_d;
        rd_div0_q    <= rd_div0_d;
        rd_written_q <= rd_written_d;
      end
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_opc     = rd_opc_q;
  assign bus.rd_op_a    = rd_a_q;
  assign bus.rd_op_b    = rd_b_q;
  assign bus.rd_result  = rd_res_q;
  assign bus.rd_div0    = rd_div0_q;
  assign bus.rd_written = rd_written_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.full       = (wr_count_q == FULL_COUNT);

endmodule

// File: doc/instr_register_param.md
INSTR_REGISTER_PARAM -- requirements
Module: instr_register_param

Interface
REQ-001 The module SHALL take parameter OP_WIDTH, default 32, meaning the signed operand width in bits.
REQ-002 The module SHALL take parameter DEPTH, default 32, meaning the number of register locations (power of two, 2..256).
REQ-003 The module SHALL use derived constants ADDR_WIDTH = $clog2(DEPTH) and RES_WIDTH = 2*OP_WIDTH.
REQ-004 Port clk SHALL be an input of width 1: the single clock, rising-edge active.
REQ-005 Port reset_n SHALL be an input of width 1: the reset, asynchronous and active-low.
REQ-006 Port load_en SHALL be an input of width 1: write request, sampled at the rising edge.
REQ-007 Port write_pointer SHALL be an input of width ADDR_WIDTH: the write location.
REQ-008 Port opcode SHALL be an input of type opcode_t (3 bits): the operation selector.
REQ-009 Ports operand_a and operand_b SHALL be inputs of width OP_WIDTH: signed operands.
REQ-010 Port clear_all SHALL be an input of width 1: synchronous invalidate of all locations.
REQ-011 Port read_en SHALL be an input of width 1: read request. Port read_pointer SHALL be an input of width ADDR_WIDTH: the read location.
REQ-012 Ports rd_opc, rd_op_a, rd_op_b and rd_result SHALL be outputs (opcode_t, OP_WIDTH, OP_WIDTH, RES_WIDTH): the registered read data.
REQ-013 Port rd_valid SHALL be an output of width 1: pulses for 1 cycle when read data is presented.
REQ-014 Ports rd_written and rd_div0 SHALL be outputs of width 1: the location-written flag and divide-by-zero flag of the read entry.
REQ-015 Port wr_count SHALL be an output of width ADDR_WIDTH+1: the number of distinct written locations. Port full SHALL be an output of width 1: wr_count == DEPTH.

Function
REQ-016 Write pipeline, stage 1: a load_en at edge E0 SHALL capture opcode, operands and pointer into the stage-1 register and mark stage 1 valid.
REQ-017 Write pipeline, stage 2: at edge E0+1 the entry SHALL commit, storing {opc, op_a, op_b, result, div0} into location write_pointer, setting its written flag. Write latency is 2 edges, fully pipelined, so back-to-back writes are accepted every cycle.
REQ-018 Results SHALL be computed as signed values, sign-extended to RES_WIDTH: ZERO=0, PASSA=a, PASSB=b, ADD=a+b, SUB=a-b, MULT=a*b at full product width, DIV=a/b truncated toward zero, MOD=a%b with the sign of a.
REQ-019 DIV or MOD with b=0 SHALL store result 0 and div0=1; all other cases SHALL store div0=0.
REQ-020 DIV of -2^(OP_WIDTH-1) by -1 SHALL store +2^(OP_WIDTH-1) without overflow.
REQ-021 A read_en at edge R SHALL register location read_pointer onto the rd_* outputs, with rd_valid=1 for the following cycle. Read latency is 1 edge.
REQ-022 When a read and a commit target the same location at the same edge, the read SHALL return the newly committed data (write-first bypass).
REQ-023 A read of an unwritten location SHALL return rd_written=0, with rd_opc/rd_op_a/rd_op_b/rd_result/rd_div0 all 0.
REQ-024 wr_count SHALL increment only on a commit to a location whose written flag was 0; an overwrite SHALL leave it unchanged, and wr_count SHALL never exceed DEPTH.
REQ-025 clear_all SHALL clear all written flags, zero wr_count, and discard the stage-1 entry at that edge; it SHALL take priority over a simultaneous commit.
REQ-026 A load_en at the same edge as clear_all SHALL be accepted into stage 1 and SHALL commit normally afterward.
REQ-027 Reads coinciding with clear_all SHALL return pre-clear contents.

Reset
REQ-028 reset_n low SHALL asynchronously clear: stage-1 valid, all written flags, all array contents, wr_count, full, rd_valid and all rd_* outputs to 0.
REQ-029 Reset asserted mid-pipeline SHALL drop the in-flight write, so that no commit occurs after reset release.
REQ-030 The first write SHALL be accepted at the first rising edge after reset_n deasserts.

Structure
REQ-031 opcode_t (ZERO=0, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD=7) SHALL reside in instr_register_pkg, together with any entry struct typedef.
REQ-032 The arithmetic SHALL be a combinational sub-module instr_alu parametrised by OP_WIDTH, producing result and div0.

Verification
REQ-033 Reset, then write loc 0 ADD a=7 b=-3, and read loc 0 two edges later -> rd_result=4, rd_written=1, rd_div0=0, rd_valid for 1 cycle.
REQ-034 Writes of DIV a=-15 b=4, MOD a=-15 b=4 and DIV a=9 b=0 -> results -3, -3, and 0 with rd_div0=1.
REQ-035 Write loc 5 PASSB a=1 b=12, with read loc 5 at the commit edge -> bypass returns 12. A prior write of 3 to the same location is never visible.
REQ-036 Write all DEPTH locations, then overwrite loc 0 -> wr_count=DEPTH and full=1 throughout. Then assert clear_all -> wr_count=0, full=0, and reads return rd_written=0.
REQ-037 With OP_WIDTH=8: MULT -128*-128 -> 16384; DIV -128/-1 -> 128.
REQ-038 Assert reset_n one cycle after load_en -> no location written, wr_count=0, and all rd_* outputs 0.
